// File: rtl/fetch_queue_stage.sv
// Fetch stage with PC register, halt FSM and a small in-order fetch queue.
// Entries carry {instr, pc}; branch redirects flush the queue.
module fetch_queue_stage #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic branch_en,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic cache_stall,
  input  logic [INSTR_W-1:0] icache_instr,
  input  logic stall_de,
  output logic [ADDR_W-1:0] icache_addr,
  output logic dq_valid,
  output logic [INSTR_W-1:0] dq_instr,
  output logic [ADDR_W-1:0] dq_pc,
  output logic [ADDR_W-1:0] dq_pc_next,
  output logic [$clog2(DEPTH+1)-1:0] dq_count,
  output logic halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fq_entry_t;

  fq_entry_t mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] pc;
  logic [0:0] state;
  logic pop;
  logic push;
  logic is_halt;

  assign dq_valid = (count != '0);
  assign pop = dq_valid & ~stall_de & ~branch_en;
  // A full queue still accepts a push when the head leaves the same cycle
  assign push = (state == FETCH) & ~cache_stall & ~branch_en
              & ((count < CW'(DEPTH)) | pop);
  assign is_halt = (icache_instr[INSTR_W-1 -: 4] == HALT_OP);

  assign icache_addr = pc;
  assign dq_instr = mem[head].instr;
  assign dq_pc = mem[head].pc;
  assign dq_pc_next = dq_pc + ADDR_W'(PC_INC);
  assign dq_count = count;
  assign halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{instr: icache_instr, pc: pc};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= FETCH;
    end else begin
      unique case (1'b1)
        branch_en: begin
          pc <= branch_pc;
          state <= FETCH;
        end
        push: begin
          if (is_halt) begin
            state <= HALTED;
          end else begin
            pc <= pc + ADDR_W'(PC_INC);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (branch_en) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      unique case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: vector table plus
// hand-written reset sequences.
module tb_fetch_queue_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic branch_en = 1'b0;
  logic [15:0] branch_pc = '0;
  logic cache_stall = 1'b0;
  logic [15:0] icache_instr = '0;
  logic stall_de = 1'b0;
  logic [15:0] icache_addr;
  logic dq_valid;
  logic [15:0] dq_instr;
  logic [15:0] dq_pc;
  logic [15:0] dq_pc_next;
  logic [2:0] dq_count;
  logic halted;

  int n_pass = 0;
  int n_total = 0;

  fetch_queue_stage dut (
    .clk(clk),
    .rst(rst),
    .branch_en(branch_en),
    .branch_pc(branch_pc),
    .cache_stall(cache_stall),
    .icache_instr(icache_instr),
    .stall_de(stall_de),
    .icache_addr(icache_addr),
    .dq_valid(dq_valid),
    .dq_instr(dq_instr),
    .dq_pc(dq_pc),
    .dq_pc_next(dq_pc_next),
    .dq_count(dq_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic br;
    logic [15:0] bpc;
    logic cs;
    logic [15:0] ins;
    logic sd;
    logic [15:0] addr;
    logic [2:0] cnt;
    logic hlt;
    logic [15:0] epc;
    logic [15:0] eins;
  } vec_t;

  vec_t vec [21];

  function automatic vec_t mk(
    logic br, logic [15:0] bpc, logic cs, logic [15:0] ins,
    logic sd, logic [15:0] addr, logic [2:0] cnt, logic hlt,
    logic [15:0] epc, logic [15:0] eins);
    vec_t v;
    v.br = br; v.bpc = bpc; v.cs = cs; v.ins = ins; v.sd = sd;
    v.addr = addr; v.cnt = cnt; v.hlt = hlt;
    v.epc = epc; v.eins = eins;
    return v;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_state(int idx, logic [15:0] addr,
                           logic [2:0] cnt, logic hlt,
                           logic [15:0] epc, logic [15:0] eins);
    logic [15:0] enext;
    enext = epc + 16'd2;
    chk("icache_addr", idx, 32'(icache_addr), 32'(addr));
    chk("dq_count", idx, 32'(dq_count), 32'(cnt));
    chk("dq_valid", idx, 32'(dq_valid), 32'(cnt != 3'd0));
    chk("halted", idx, 32'(halted), 32'(hlt));
    if (cnt != 3'd0) begin
      chk("dq_pc", idx, 32'(dq_pc), 32'(epc));
      chk("dq_pc_next", idx, 32'(dq_pc_next), 32'(enext));
      chk("dq_instr", idx, 32'(dq_instr), 32'(eins));
    end
  endtask

  initial begin
    //        br bpc      cs ins      sd addr     cnt hlt epc      eins
    vec[0]  = mk(0, 16'h0, 0, 16'h1000, 1, 16'h0002, 1, 0, 16'h0000, 16'h1000);
    vec[1]  = mk(0, 16'h0, 0, 16'h1002, 1, 16'h0004, 2, 0, 16'h0000, 16'h1000);
    vec[2]  = mk(0, 16'h0, 0, 16'h1004, 1, 16'h0006, 3, 0, 16'h0000, 16'h1000);
    vec[3]  = mk(0, 16'h0, 0, 16'h1006, 1, 16'h0008, 4, 0, 16'h0000, 16'h1000);
    vec[4]  = mk(0, 16'h0, 0, 16'h1008, 1, 16'h0008, 4, 0, 16'h0000, 16'h1000);
    vec[5]  = mk(0, 16'h0, 0, 16'h1008, 1, 16'h0008, 4, 0, 16'h0000, 16'h1000);
    vec[6]  = mk(0, 16'h0, 0, 16'h1008, 0, 16'h000A, 4, 0, 16'h0002, 16'h1002);
    vec[7]  = mk(1, 16'h4, 0, 16'h100A, 0, 16'h0004, 0, 0, 16'h0000, 16'h0000);
    vec[8]  = mk(0, 16'h0, 0, 16'hF000, 1, 16'h0004, 1, 1, 16'h0004, 16'hF000);
    vec[9]  = mk(0, 16'h0, 0, 16'h1234, 0, 16'h0004, 0, 1, 16'h0000, 16'h0000);
    vec[10] = mk(0, 16'h0, 0, 16'h1234, 0, 16'h0004, 0, 1, 16'h0000, 16'h0000);
    vec[11] = mk(1, 16'h40, 0, 16'h1234, 0, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    vec[12] = mk(0, 16'h0, 0, 16'h2040, 1, 16'h0042, 1, 0, 16'h0040, 16'h2040);
    vec[13] = mk(0, 16'h0, 0, 16'h2042, 1, 16'h0044, 2, 0, 16'h0040, 16'h2040);
    vec[14] = mk(0, 16'h0, 1, 16'hDEAD, 0, 16'h0044, 1, 0, 16'h0042, 16'h2042);
    vec[15] = mk(0, 16'h0, 1, 16'hDEAD, 0, 16'h0044, 0, 0, 16'h0000, 16'h0000);
    vec[16] = mk(0, 16'h0, 1, 16'hDEAD, 0, 16'h0044, 0, 0, 16'h0000, 16'h0000);
    vec[17] = mk(0, 16'h0, 0, 16'h2044, 1, 16'h0046, 1, 0, 16'h0044, 16'h2044);
    vec[18] = mk(1, 16'hFFFE, 0, 16'h2046, 1, 16'hFFFE, 0, 0, 16'h0000, 16'h0000);
    vec[19] = mk(0, 16'h0, 0, 16'h3000, 1, 16'h0000, 1, 0, 16'hFFFE, 16'h3000);
    vec[20] = mk(0, 16'h0, 0, 16'h3002, 1, 16'h0002, 2, 0, 16'hFFFE, 16'h3000);

    #1 rst = 1'b1;
    #1 chk_state(100, 16'h0000, 3'd0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      branch_en = vec[i].br;
      branch_pc = vec[i].bpc;
      cache_stall = vec[i].cs;
      icache_instr = vec[i].ins;
      stall_de = vec[i].sd;
      @(posedge clk);
      #1;
      chk_state(i, vec[i].addr, vec[i].cnt, vec[i].hlt,
                vec[i].epc, vec[i].eins);
    end

    // Asynchronous reset in the middle of a non-empty queue
    #1 rst = 1'b1;
    #1 chk_state(101, 16'h0000, 3'd0, 1'b0, 16'h0, 16'h0);
    #1 rst = 1'b0;
    branch_en = 1'b0;
    cache_stall = 1'b0;
    stall_de = 1'b1;
    icache_instr = 16'h4000;
    @(posedge clk);
    #1 chk_state(102, 16'h0002, 3'd1, 1'b0, 16'h0000, 16'h4000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
